// File: rtl/arb_rr4_sel_pkg.sv
// Shared definitions for the four-way round-robin arbiter and the 4:1 mux it drives.
//   state_e      : arbiter FSM encoding (ST_IDLE / ST_GRANT)
//   SEL_A..SEL_D : mux select codes for channels a..d
//   onehot4()    : converts a 2-bit select into a one-hot grant vector
package arb_rr4_sel_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [3:0] onehot4(logic [1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/arb_rr4_sel_if.sv
// Requester-side bundle of the arbiter.
//   req  : per-channel request lines
//   done : release pulse from the granted channel
//   s    : 2-bit select to the 4:1 mux
//   gnt  : one-hot grant (zero when idle)
//   busy : a grant is active
// master = requesters / bench, slave = arbiter.
interface arb_rr4_sel_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       busy;

  modport master (
    output req,
    output done,
    input  s,
    input  gnt,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output s,
    output gnt,
    output busy
  );
endinterface

// File: rtl/arb_rr4_sel_rr_pick4.sv
// Combinational round-robin winner search over four requesters.
//   i_req     : request vector
//   i_ptr     : highest-priority index for this search
//   o_win     : first requesting index found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   o_any_req : at least one request is present (o_win is meaningless otherwise)
module arb_rr4_sel_rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_win,
  output logic       o_any_req
);

  logic [1:0] w_idx;

  // Scan from the farthest offset back towards ptr so the nearest request overwrites last.
  always_comb begin
    o_win     = i_ptr;
    o_any_req = |i_req;
    w_idx     = i_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_req[w_idx]) begin
        o_win = w_idx;
      end
    end
  end

endmodule

// File: rtl/arb_rr4_sel.sv
// Round-robin arbiter for four requesters, driving the select of a downstream 4:1 mux.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-low reset
//   bus   : slave side of arb_rr4_sel_if (req/done in, s/gnt/busy out)
// A grant lasts until done, the owner drops its request, or HOLD_MAX cycles elapse. Every
// release is followed by at least one idle cycle, so s never moves while gnt is nonzero.
// HOLD_MAX must lie in 1..15 and fit in CNT_W bits.
module arb_rr4_sel
  import arb_rr4_sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  arb_rr4_sel_if.slave  bus
);

  localparam logic [CNT_W-1:0] HoldMaxC = CNT_W'(HOLD_MAX);

  state_e           r_state, w_state_next;
  logic [1:0]       r_ptr, w_ptr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_s, w_s_next;
  logic [3:0]       r_gnt, w_gnt_next;
  logic             r_busy, w_busy_next;

  logic [1:0]       w_win;
  logic             w_any_req;
  logic             w_release;

  arb_rr4_sel_rr_pick4 u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_any_req (w_any_req)
  );

  // Any combination of release causes collapses into a single release.
  assign w_release = bus.done | ~bus.req[r_s] | (r_cnt == HoldMaxC);

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_s_next     = r_s;
    w_gnt_next   = r_gnt;
    w_busy_next  = r_busy;
    unique case (r_state)
      ST_IDLE: begin
        // done is deliberately ignored here; s keeps its last value when nobody asks.
        if (w_any_req) begin
          w_s_next     = w_win;
          w_gnt_next   = onehot4(w_win);
          w_busy_next  = 1'b1;
          w_cnt_next   = CNT_W'(1);
          w_state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_gnt_next   = 4'b0000;
          w_busy_next  = 1'b0;
          w_ptr_next   = r_s + 2'd1;
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= SEL_A;
      r_cnt   <= '0;
      r_s     <= SEL_A;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_s     <= w_s_next;
      r_gnt   <= w_gnt_next;
      r_busy  <= w_busy_next;
    end
  end

  assign bus.s    = r_s;
  assign bus.gnt  = r_gnt;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_arb_rr4_sel.sv
// Self-checking bench for arb_rr4_sel: a behavioural model predicts s/gnt/busy after every
// edge and queues the prediction; a monitor pops and compares one step after each edge.
module tb_arb_rr4_sel;

  localparam int unsigned HoldMax = 4;

  typedef struct {
    logic [1:0] s;
    logic [3:0] gnt;
    logic       busy;
  } exp_t;

  logic clk;
  logic reset;
  arb_rr4_sel_if bus ();

  arb_rr4_sel #(
    .HOLD_MAX (HoldMax),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: who owns the mux, for how long, and where the next search starts.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_start = 0;
  logic [1:0] m_s     = 2'b00;

  always @(posedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      m_owner = -1;
      m_age   = 0;
      m_start = 0;
      m_s     = 2'b00;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_start + k) % 4;
        if (m_owner < 0 && bus.req[c]) begin
          m_owner = c;
          m_age   = 1;
          m_s     = 2'(c);
        end
      end
    end else begin
      if (bus.done || !bus.req[m_owner] || m_age == int'(HoldMax)) begin
        m_start = (m_owner + 1) % 4;
        m_owner = -1;
        m_age   = 0;
      end else begin
        m_age++;
      end
    end
    e.s    = m_s;
    e.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.busy = (m_owner >= 0);
    exp_q.push_back(e);
  end

  // Monitor: every edge produces a registered output, compared once it has settled.
  logic [1:0] prev_s;
  logic       prev_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      chk("s", 32'(bus.s), 32'(e.s));
      chk("gnt", 32'(bus.gnt), 32'(e.gnt));
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("gnt_onehot0", 32'($countones(bus.gnt) <= 1), 32'(1));
      chk("busy_eq_gnt", 32'(bus.busy), 32'(bus.gnt != 4'b0000));
      if (bus.gnt != 4'b0000) chk("gnt_at_s", 32'(bus.gnt[bus.s]), 32'(1));
      if (prev_busy && bus.busy) chk("s_stable", 32'(bus.s), 32'(prev_s));
      prev_s    = bus.s;
      prev_busy = bus.busy;
    end
  end

  task automatic drive(input logic rst_n, input logic [3:0] r, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset    = rst_n;
      bus.req  = r;
      bus.done = d;
    end
  endtask

  initial begin
    reset    = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;

    // Reset with all requests up, then free-running fairness with period 5.
    drive(1'b0, 4'b1111, 1'b0, 2);
    drive(1'b1, 4'b1111, 1'b0, 26);

    // Early release via done on the second grant cycle of channel b.
    drive(1'b0, 4'b0110, 1'b0, 1);
    drive(1'b1, 4'b0110, 1'b0, 2);
    drive(1'b1, 4'b0110, 1'b1, 1);
    drive(1'b1, 4'b0110, 1'b0, 6);

    // Channel d: withdraw, done and budget expiry in the same cycle, then re-grant to d.
    drive(1'b0, 4'b1000, 1'b0, 1);
    drive(1'b1, 4'b1000, 1'b0, 4);
    drive(1'b1, 4'b0000, 1'b1, 1);
    drive(1'b1, 4'b1000, 1'b0, 8);

    // Reset in the middle of a grant to channel c, then restart from ptr=0.
    drive(1'b1, 4'b0100, 1'b0, 3);
    drive(1'b0, 4'b0100, 1'b0, 1);
    drive(1'b1, 4'b1101, 1'b0, 6);

    // done while idle must be ignored.
    drive(1'b1, 4'b0000, 1'b1, 3);

    // Randomized traffic with occasional done pulses and rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic       d;
      logic       rn;
      r  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 80) != 0);
      drive(rn, r, d, $urandom_range(1, 4));
    end

    drive(1'b1, 4'b0000, 1'b0, 3);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
